hazard_md: RTL and testbench
============================

Name: hazard_md

Overview:
- Next-generation hazard unit for the 5-stage MIPS pipeline, generalised in register-file width and in execution latency.
- Keeps the existing D-stage and E-stage forwarding and the load-use and branch stalls.
- Adds a sequential scoreboard for one multi-cycle multiply/divide (MD) unit with a configurable latency. It raises RAW and structural stalls until the MD result reaches the register file.

Parameters:
REGBITS, 5, register-specifier width; register 0 is hardwired zero.
MD_LATENCY, 4, cycles from MD issue in E to the result write; legal range 2..15.
CNTBITS, 4, width of the MD countdown counter; must satisfy MD_LATENCY-2 < 2**CNTBITS.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
rsD, rtD  in  REGBITS  D-stage source registers
rsE, rtE  in  REGBITS  E-stage source registers
writeregE, writeregM, writeregW  in  REGBITS  destination register per stage
regwriteE, regwriteM, regwriteW  in  1  register-write enable per stage
memtoregE, memtoregM  in  1  load in E / in M
branchD  in  1  branch compare in D
mdopD  in  1  D instruction is an MD op
mdstartE  in  1  MD op in E this cycle (issue)
mdwriteregE  in  REGBITS  MD destination register
forwardaD, forwardbD  out  1  ALUOutM to the D-stage comparator
forwardaE, forwardbE  out  2  00 = regfile, 01 = ResultW, 10 = ALUOutM
stallF, stallD, flushE  out  1  pipeline control
mdbusy  out  1  MD op outstanding (state BUSY)
mddoneW  out  1  one-cycle pulse; MD result is written to the regfile this cycle
stallcnt, mdstallcnt  out  32  performance counters (see Optional Feature)

Behaviour:
- Reset, asynchronous: state = IDLE, count = 0, mdreg = 0. While reset is asserted all outputs are 0.
- D forwarding, combinational: forwardaD = (rsD != 0) & (rsD == writeregM) & regwriteM. forwardbD is the same using rtD.
- E forwarding, combinational, per operand:
  - source register 0 → 00.
  - match on writeregM with regwriteM → 10. This has priority over W.
  - else match on writeregW with regwriteW → 01.
  - else 00.
- lwstall = memtoregE & ((rtE == rsD) | (rtE == rtD)).
- branchstall = branchD & ( regwriteE & (writeregE == rsD | writeregE == rtD) | memtoregM & (writeregM == rsD | writeregM == rtD) ).
- MD state machine, states IDLE, BUSY, DONE:
  - IDLE: if mdstartE → BUSY, count = MD_LATENCY-2, mdreg = mdwriteregE.
  - BUSY: count decrements by 1 each cycle. When count == 0 → DONE.
  - DONE: mddoneW = 1. If mdstartE → BUSY and reload count and mdreg; else → IDLE.
  - Timing: issue in cycle t gives mddoneW high in exactly cycle t+MD_LATENCY.
- mdbusy = (state == BUSY).
- mdrawstall is asserted when either condition holds, with mdreg != 0 and mdwriteregE != 0 respectively:
  - state == BUSY and mdreg matches rsD or rtD;
  - mdstartE and mdwriteregE matches rsD or rtD.
- No stall is needed in DONE: the regfile writes in the first half-cycle, so a D read in DONE gets the MD result.
- mdstructstall = mdopD & (mdbusy | mdstartE). A second MD op waits in D; it may leave D in DONE.
- stallD = lwstall | branchstall | mdrawstall | mdstructstall. stallF = stallD, flushE = stallD.
- Simultaneous events:
  - A stall never blocks the FSM; the instruction already in E proceeds.
  - A normal regwriteW and mddoneW in the same cycle use separate regfile ports; the unit imposes no ordering.
- Reset mid-BUSY aborts the MD op: no mddoneW pulse, and the stalls clear immediately.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - stallcnt increments on every cycle with stallD = 1.
  - mdstallcnt increments on cycles where mdrawstall | mdstructstall.
  - Both counters are 32-bit, wrap at 2**32, and reset to 0 asynchronously.
- Undefined: both outputs are tied to 0 and no counter flops are generated.

Decomposition:
- hazard_pkg: md_state_t enum (IDLE, BUSY, DONE); forwarding constants FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
- One sub-module, md_scoreboard: holds the FSM, counter and mdreg, and produces mdbusy, mddoneW and mdrawstall.
- The top level keeps the combinational forwarding and stall logic.

Test Plan:
1. rsE = 3, writeregM = 3, regwriteM = 1, writeregW = 3, regwriteW = 1 → forwardaE = 10. Then clear regwriteM → forwardaE = 01. Then rsE = 0 → 00.
2. memtoregE = 1, rtE = 5, rsD = 5 → stallF = stallD = flushE = 1 for one cycle, then 0.
3. mdstartE with mdwriteregE = 8 at cycle 0, MD_LATENCY = 4 → mdbusy high in cycles 1–3; mddoneW high in cycle 4 only.
4. With an MD op outstanding to reg 8, hold rsD = 8 → stallD high in cycles 0–3 and low in cycle 4. With mdwriteregE = 0, stallD is never raised.
5. mdopD = 1 while BUSY → stallD held until DONE. A back-to-back mdstartE in DONE reloads BUSY with no IDLE cycle.
6. Assert reset in cycle 2 of a BUSY period → mdbusy = 0 and stallD = 0 immediately; no mddoneW pulse. With HAZARD_PERF_EN defined, both counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// ============================================================================
// hazard_pkg
// Shared types and constants for the hazard_md pipeline hazard unit.
//   md_state_t : state of the multiply/divide scoreboard (IDLE, BUSY, DONE)
//   FWD_*      : encodings of the E-stage forwarding multiplexer selects
// ============================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_md_scoreboard.sv
// ============================================================================
// md_scoreboard
// Tracks the single outstanding multi-cycle multiply/divide operation.
// An issue in E loads a countdown and remembers the destination register;
// the FSM walks IDLE -> BUSY -> DONE so that DONE lands exactly MD_LATENCY
// cycles after the issue cycle, which is the cycle the result is written.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   mdstartE          MD operation issuing from E this cycle
//   mdwriteregE       destination register of the issuing MD operation
//   rsD, rtD          D-stage source registers (RAW check)
//   mdbusy            state is BUSY
//   mddoneW           state is DONE (result written to regfile this cycle)
//   mdrawstall        D-stage instruction reads the pending MD destination
// ============================================================================
import hazard_pkg::*;

module md_scoreboard #(
    parameter int REGBITS    = 5,
    parameter int MD_LATENCY = 4,
    parameter int CNTBITS    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mdstartE,
    input  logic [REGBITS-1:0] mdwriteregE,
    input  logic [REGBITS-1:0] rsD,
    input  logic [REGBITS-1:0] rtD,
    output logic               mdbusy,
    output logic               mddoneW,
    output logic               mdrawstall
);

    // BUSY lasts MD_LATENCY-1 cycles (count runs down to 0 inclusive), and
    // DONE follows, giving the result write at issue + MD_LATENCY.
    localparam logic [CNTBITS-1:0] RELOAD = CNTBITS'(MD_LATENCY - 2);

    md_state_t          state_q, state_d;
    logic [CNTBITS-1:0] count_q, count_d;
    logic [REGBITS-1:0] mdreg_q, mdreg_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            mdreg_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mdreg_q <= mdreg_d;
        end
    end

    // DONE behaves like IDLE for a new issue, so back-to-back MD ops reload
    // straight into BUSY without an idle bubble.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mdreg_d = mdreg_q;
        case (state_q)
            IDLE, DONE: begin
                if (mdstartE) begin
                    state_d = BUSY;
                    count_d = RELOAD;
                    mdreg_d = mdwriteregE;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (count_q == '0) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q - CNTBITS'(1);
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                mdreg_d = '0;
            end
        endcase
    end

    // No stall in DONE: the regfile writes in the first half-cycle, so a
    // D-stage read in DONE already sees the MD result.
    always_comb begin
        mdbusy     = (state_q == BUSY);
        mddoneW    = (state_q == DONE);
        mdrawstall = ((state_q == BUSY) && (mdreg_q != '0) &&
                      ((mdreg_q == rsD) || (mdreg_q == rtD)))
                  || (mdstartE && (mdwriteregE != '0) &&
                      ((mdwriteregE == rsD) || (mdwriteregE == rtD)));
    end

endmodule

// File: rtl/hazard_md.sv
// ============================================================================
// hazard_md
// Hazard unit for the 5-stage MIPS pipeline with a multi-cycle MD unit.
// Provides D- and E-stage forwarding selects, load-use and branch stalls,
// and MD RAW / structural stalls from the md_scoreboard sub-module.
//
// Optional feature (macro HAZARD_PERF_EN): 32-bit performance counters
// stallcnt (cycles with stallD) and mdstallcnt (cycles with an MD stall).
// Without the macro both outputs are constant 0.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   rsD, rtD, rsE, rtE               source registers in D and E
//   writereg{E,M,W}, regwrite{E,M,W} destination register / write enable
//   memtoregE, memtoregM             load in E / in M
//   branchD, mdopD                   D instruction is a branch / MD op
//   mdstartE, mdwriteregE            MD issue from E and its destination
//   forwarda/bD                      ALUOutM to the D-stage comparator
//   forwarda/bE                      E operand select (FWD_RF/WB/MEM)
//   stallF, stallD, flushE           pipeline control
//   mdbusy, mddoneW                  MD outstanding / MD result write pulse
//   stallcnt, mdstallcnt             performance counters
// All outputs are forced to 0 while reset is asserted.
// ============================================================================
import hazard_pkg::*;

module hazard_md #(
    parameter int REGBITS    = 5,
    parameter int MD_LATENCY = 4,
    parameter int CNTBITS    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [REGBITS-1:0] rsD,
    input  logic [REGBITS-1:0] rtD,
    input  logic [REGBITS-1:0] rsE,
    input  logic [REGBITS-1:0] rtE,
    input  logic [REGBITS-1:0] writeregE,
    input  logic [REGBITS-1:0] writeregM,
    input  logic [REGBITS-1:0] writeregW,
    input  logic               regwriteE,
    input  logic               regwriteM,
    input  logic               regwriteW,
    input  logic               memtoregE,
    input  logic               memtoregM,
    input  logic               branchD,
    input  logic               mdopD,
    input  logic               mdstartE,
    input  logic [REGBITS-1:0] mdwriteregE,
    output logic               forwardaD,
    output logic               forwardbD,
    output logic [1:0]         forwardaE,
    output logic [1:0]         forwardbE,
    output logic               stallF,
    output logic               stallD,
    output logic               flushE,
    output logic               mdbusy,
    output logic               mddoneW,
    output logic [31:0]        stallcnt,
    output logic [31:0]        mdstallcnt
);

    logic sb_busy, sb_done, sb_rawstall;
    logic lwstall, branchstall, mdstructstall, mdstall_any, stall_any;

    md_scoreboard #(
        .REGBITS   (REGBITS),
        .MD_LATENCY(MD_LATENCY),
        .CNTBITS   (CNTBITS)
    ) u_md_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .mdstartE   (mdstartE),
        .mdwriteregE(mdwriteregE),
        .rsD        (rsD),
        .rtD        (rtD),
        .mdbusy     (sb_busy),
        .mddoneW    (sb_done),
        .mdrawstall (sb_rawstall)
    );

    // M-stage match wins over W because it carries the younger value.
    function automatic logic [1:0] fwd_sel(
        input logic [REGBITS-1:0] src,
        input logic [REGBITS-1:0] wreg_m,
        input logic               wen_m,
        input logic [REGBITS-1:0] wreg_w,
        input logic               wen_w
    );
        if (src == '0)                   return FWD_RF;
        else if (wen_m && src == wreg_m) return FWD_MEM;
        else if (wen_w && src == wreg_w) return FWD_WB;
        else                             return FWD_RF;
    endfunction

    always_comb begin
        lwstall       = memtoregE & ((rtE == rsD) | (rtE == rtD));
        branchstall   = branchD &
                        ((regwriteE & ((writeregE == rsD) | (writeregE == rtD))) |
                         (memtoregM & ((writeregM == rsD) | (writeregM == rtD))));
        mdstructstall = mdopD & (sb_busy | mdstartE);
        mdstall_any   = ~reset & (sb_rawstall | mdstructstall);
        stall_any     = ~reset & (lwstall | branchstall | sb_rawstall | mdstructstall);
    end

    // Combinational outputs are gated with reset so that every output is 0
    // while reset is held, regardless of the pipeline inputs.
    always_comb begin
        forwardaD = 1'b0;
        forwardbD = 1'b0;
        forwardaE = FWD_RF;
        forwardbE = FWD_RF;
        mdbusy    = 1'b0;
        mddoneW   = 1'b0;
        if (!reset) begin
            forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
            forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;
            forwardaE = fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
            forwardbE = fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);
            mdbusy    = sb_busy;
            mddoneW   = sb_done;
        end
        stallD = stall_any;
        stallF = stall_any;
        flushE = stall_any;
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stallcnt_q, stallcnt_d;
    logic [31:0] mdstallcnt_q, mdstallcnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallcnt_q   <= '0;
            mdstallcnt_q <= '0;
        end else begin
            stallcnt_q   <= stallcnt_d;
            mdstallcnt_q <= mdstallcnt_d;
        end
    end

    // Counters wrap naturally at 2**32.
    always_comb begin
        stallcnt_d   = stallcnt_q + {31'd0, stall_any};
        mdstallcnt_d = mdstallcnt_q + {31'd0, mdstall_any};
    end

    assign stallcnt   = stallcnt_q;
    assign mdstallcnt = mdstallcnt_q;
`else
    assign stallcnt   = '0;
    assign mdstallcnt = '0;
`endif

endmodule

// File: tb/tb_hazard_md.sv
// ============================================================================
// tb_hazard_md
// Self-checking bench for hazard_md. Each cycle the stimulus is applied one
// time unit after the rising edge, the expected outputs are pushed into a
// queue, and they are popped and compared a few time units later.
// ============================================================================
module tb_hazard_md;

    localparam int RB   = 5;
    localparam int L    = 4;
    localparam int NONE = -1000;

    logic          clk = 1'b0;
    logic          reset;
    logic [RB-1:0] rsD, rtD, rsE, rtE;
    logic [RB-1:0] writeregE, writeregM, writeregW;
    logic          regwriteE, regwriteM, regwriteW;
    logic          memtoregE, memtoregM, branchD, mdopD, mdstartE;
    logic [RB-1:0] mdwriteregE;
    logic          forwardaD, forwardbD;
    logic [1:0]    forwardaE, forwardbE;
    logic          stallF, stallD, flushE, mdbusy, mddoneW;
    logic [31:0]   stallcnt, mdstallcnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [1:0] a; logic [1:0] b; } fwdexp_t;
    typedef struct packed { logic busy; logic done; logic stall; } mdexp_t;

    fwdexp_t fwdq[$];
    logic    stq[$];
    mdexp_t  mdq[$];

    hazard_md #(.REGBITS(RB), .MD_LATENCY(L), .CNTBITS(4)) dut (
        .clk(clk), .reset(reset),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .mdopD(mdopD), .mdstartE(mdstartE),
        .mdwriteregE(mdwriteregE),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .mdbusy(mdbusy), .mddoneW(mddoneW),
        .stallcnt(stallcnt), .mdstallcnt(mdstallcnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Timing model of the MD unit from issue cycles: busy strictly between
    // issue and issue+L, result write exactly at issue+L.
    function automatic logic model_busy(int c, int i0, int i1, int i2);
        return (c > i0 && c < i0 + L) || (c > i1 && c < i1 + L) ||
               (c > i2 && c < i2 + L);
    endfunction

    function automatic logic model_done(int c, int i0, int i1, int i2);
        return (c == i0 + L) || (c == i1 + L) || (c == i2 + L);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic clear_inputs();
        rsD = '0; rtD = '0; rsE = '0; rtE = '0;
        writeregE = '0; writeregM = '0; writeregW = '0;
        regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
        memtoregE = 1'b0; memtoregM = 1'b0; branchD = 1'b0;
        mdopD = 1'b0; mdstartE = 1'b0; mdwriteregE = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        rsD = 5'd3; writeregM = 5'd3; regwriteM = 1'b1; rsE = 5'd3;
        memtoregE = 1'b1; rtE = 5'd3; mdstartE = 1'b1; mdwriteregE = 5'd3;
        repeat (2) step();
        settle();
        checks++; if (forwardaD !== 1'b0) begin errors++; $display("[TB] FAIL reset_forwardaD: got %0b expected 0", forwardaD); end
        checks++; if (forwardaE !== 2'b00) begin errors++; $display("[TB] FAIL reset_forwardaE: got %0b expected 00", forwardaE); end
        checks++; if (stallD !== 1'b0) begin errors++; $display("[TB] FAIL reset_stallD: got %0b expected 0", stallD); end
        checks++; if (mdbusy !== 1'b0 || mddoneW !== 1'b0) begin errors++; $display("[TB] FAIL reset_md: got busy=%0b done=%0b expected 0 0", mdbusy, mddoneW); end
        checks++; if (stallcnt !== 32'd0 || mdstallcnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_counters: got %0d %0d expected 0 0", stallcnt, mdstallcnt); end
        clear_inputs();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_forward_e();
        // rsE, rtE, writeregM, regwriteM, writeregW, regwriteW, expA, expB
        int tab [6][8] = '{
            '{3, 0, 3, 1, 3, 1, 2, 0},
            '{3, 0, 3, 0, 3, 1, 1, 0},
            '{0, 0, 3, 1, 3, 1, 0, 0},
            '{7, 9, 9, 1, 7, 1, 1, 2},
            '{7, 9, 4, 1, 5, 1, 0, 0},
            '{7, 7, 7, 0, 7, 0, 0, 0}
        };
        fwdexp_t e;
        for (int i = 0; i < 6; i++) begin
            step();
            clear_inputs();
            rsE = RB'(tab[i][0]); rtE = RB'(tab[i][1]);
            writeregM = RB'(tab[i][2]); regwriteM = tab[i][3][0];
            writeregW = RB'(tab[i][4]); regwriteW = tab[i][5][0];
            fwdq.push_back('{a: 2'(tab[i][6]), b: 2'(tab[i][7])});
            settle();
            e = fwdq.pop_front();
            checks++; if (forwardaE !== e.a) begin errors++; $display("[TB] FAIL fwdE_a[%0d]: got %0b expected %0b", i, forwardaE, e.a); end
            checks++; if (forwardbE !== e.b) begin errors++; $display("[TB] FAIL fwdE_b[%0d]: got %0b expected %0b", i, forwardbE, e.b); end
        end
    endtask

    task automatic test_forward_d();
        // rsD, rtD, writeregM, regwriteM, expA, expB
        int tab [4][6] = '{
            '{4, 6, 4, 1, 1, 0},
            '{0, 0, 0, 1, 0, 0},
            '{4, 6, 6, 1, 0, 1},
            '{4, 4, 4, 0, 0, 0}
        };
        fwdexp_t e;
        for (int i = 0; i < 4; i++) begin
            step();
            clear_inputs();
            rsD = RB'(tab[i][0]); rtD = RB'(tab[i][1]);
            writeregM = RB'(tab[i][2]); regwriteM = tab[i][3][0];
            fwdq.push_back('{a: 2'(tab[i][4]), b: 2'(tab[i][5])});
            settle();
            e = fwdq.pop_front();
            checks++; if ({1'b0, forwardaD} !== e.a) begin errors++; $display("[TB] FAIL fwdD_a[%0d]: got %0b expected %0b", i, forwardaD, e.a[0]); end
            checks++; if ({1'b0, forwardbD} !== e.b) begin errors++; $display("[TB] FAIL fwdD_b[%0d]: got %0b expected %0b", i, forwardbD, e.b[0]); end
        end
    endtask

    task automatic test_stalls();
        // memtoregE, rtE, rsD, rtD, branchD, regwriteE, writeregE, memtoregM, writeregM, exp
        int tab [8][10] = '{
            '{1, 5, 5, 0, 0, 0, 0, 0, 0, 1},
            '{0, 5, 5, 0, 0, 0, 0, 0, 0, 0},
            '{1, 5, 2, 5, 0, 0, 0, 0, 0, 1},
            '{1, 5, 2, 3, 0, 0, 0, 0, 0, 0},
            '{0, 0, 2, 3, 1, 1, 2, 0, 0, 1},
            '{0, 0, 2, 3, 1, 0, 2, 0, 0, 0},
            '{0, 0, 2, 3, 1, 0, 0, 1, 3, 1},
            '{0, 0, 2, 3, 0, 1, 2, 1, 3, 0}
        };
        logic e;
        for (int i = 0; i < 8; i++) begin
            step();
            clear_inputs();
            memtoregE = tab[i][0][0]; rtE = RB'(tab[i][1]);
            rsD = RB'(tab[i][2]); rtD = RB'(tab[i][3]);
            branchD = tab[i][4][0]; regwriteE = tab[i][5][0];
            writeregE = RB'(tab[i][6]); memtoregM = tab[i][7][0];
            writeregM = RB'(tab[i][8]);
            stq.push_back(tab[i][9][0]);
            settle();
            e = stq.pop_front();
            checks++; if (stallD !== e) begin errors++; $display("[TB] FAIL stallD[%0d]: got %0b expected %0b", i, stallD, e); end
            checks++; if (stallF !== e) begin errors++; $display("[TB] FAIL stallF[%0d]: got %0b expected %0b", i, stallF, e); end
            checks++; if (flushE !== e) begin errors++; $display("[TB] FAIL flushE[%0d]: got %0b expected %0b", i, flushE, e); end
        end
        step();
        clear_inputs();
    endtask

    task automatic test_md_timing();
        mdexp_t e;
        for (int c = 0; c <= L + 1; c++) begin
            step();
            clear_inputs();
            mdstartE = (c == 0); mdwriteregE = 5'd8;
            mdq.push_back('{busy: model_busy(c, 0, NONE, NONE),
                            done: model_done(c, 0, NONE, NONE), stall: 1'b0});
            settle();
            e = mdq.pop_front();
            checks++; if (mdbusy !== e.busy) begin errors++; $display("[TB] FAIL md_timing_busy c%0d: got %0b expected %0b", c, mdbusy, e.busy); end
            checks++; if (mddoneW !== e.done) begin errors++; $display("[TB] FAIL md_timing_done c%0d: got %0b expected %0b", c, mddoneW, e.done); end
            checks++; if (stallD !== e.stall) begin errors++; $display("[TB] FAIL md_timing_stall c%0d: got %0b expected %0b", c, stallD, e.stall); end
        end
    endtask

    task automatic test_md_raw();
        mdexp_t e;
        for (int pass = 0; pass < 2; pass++) begin
            for (int c = 0; c <= L + 1; c++) begin
                step();
                clear_inputs();
                mdstartE = (c == 0);
                mdwriteregE = (pass == 0) ? 5'd8 : 5'd0;
                rsD = (pass == 0) ? 5'd8 : 5'd0;
                mdq.push_back('{busy: model_busy(c, 0, NONE, NONE),
                                done: model_done(c, 0, NONE, NONE),
                                stall: (pass == 0) && (c < L)});
                settle();
                e = mdq.pop_front();
                checks++; if (stallD !== e.stall) begin errors++; $display("[TB] FAIL md_raw_stall p%0d c%0d: got %0b expected %0b", pass, c, stallD, e.stall); end
                checks++; if (mddoneW !== e.done) begin errors++; $display("[TB] FAIL md_raw_done p%0d c%0d: got %0b expected %0b", pass, c, mddoneW, e.done); end
            end
        end
    endtask

    task automatic test_back_to_back();
        mdexp_t e;
        int     i0 = 0, i1 = L + 1, i2 = 2 * L + 1;
        logic   op, st, bz;
        for (int c = 0; c <= 3 * L + 2; c++) begin
            step();
            clear_inputs();
            st = (c == i0) || (c == i1) || (c == i2);
            op = (c >= 1) && (c <= L);
            mdstartE = st; mdopD = op; mdwriteregE = 5'd8;
            bz = model_busy(c, i0, i1, i2);
            mdq.push_back('{busy: bz, done: model_done(c, i0, i1, i2),
                            stall: op & (bz | st)});
            settle();
            e = mdq.pop_front();
            checks++; if (mdbusy !== e.busy) begin errors++; $display("[TB] FAIL b2b_busy c%0d: got %0b expected %0b", c, mdbusy, e.busy); end
            checks++; if (mddoneW !== e.done) begin errors++; $display("[TB] FAIL b2b_done c%0d: got %0b expected %0b", c, mddoneW, e.done); end
            checks++; if (stallD !== e.stall) begin errors++; $display("[TB] FAIL b2b_stall c%0d: got %0b expected %0b", c, stallD, e.stall); end
        end
    endtask

    task automatic test_reset_mid_busy();
        mdexp_t e;
        for (int c = 0; c <= L + 2; c++) begin
            step();
            clear_inputs();
            mdstartE = (c == 0); mdwriteregE = 5'd8; rsD = 5'd8; mdopD = 1'b1;
            reset = (c == 2);
            mdq.push_back('{busy: (c == 1), done: 1'b0, stall: (c < 2)});
            settle();
            e = mdq.pop_front();
            checks++; if (mdbusy !== e.busy) begin errors++; $display("[TB] FAIL rstmid_busy c%0d: got %0b expected %0b", c, mdbusy, e.busy); end
            checks++; if (mddoneW !== e.done) begin errors++; $display("[TB] FAIL rstmid_done c%0d: got %0b expected %0b", c, mddoneW, e.done); end
            checks++; if (stallD !== e.stall) begin errors++; $display("[TB] FAIL rstmid_stall c%0d: got %0b expected %0b", c, stallD, e.stall); end
            if (c == 2) begin
                checks++; if (stallcnt !== 32'd0 || mdstallcnt !== 32'd0) begin errors++; $display("[TB] FAIL rstmid_counters: got %0d %0d expected 0 0", stallcnt, mdstallcnt); end
            end
        end
    endtask

    task automatic test_perf();
        logic [31:0] exp_all, exp_md;
        for (int c = 0; c < 3; c++) begin
            step();
            clear_inputs();
            memtoregE = 1'b1; rtE = 5'd5; rsD = 5'd5;
        end
        for (int c = 0; c <= L; c++) begin
            step();
            clear_inputs();
            mdstartE = (c == 0); mdwriteregE = 5'd9; rsD = 5'd9;
        end
        step();
        clear_inputs();
        settle();
`ifdef HAZARD_PERF_EN
        exp_all = 32'(3 + L);
        exp_md  = 32'(L);
`else
        exp_all = 32'd0;
        exp_md  = 32'd0;
`endif
        checks++; if (stallcnt !== exp_all) begin errors++; $display("[TB] FAIL perf_stallcnt: got %0d expected %0d", stallcnt, exp_all); end
        checks++; if (mdstallcnt !== exp_md) begin errors++; $display("[TB] FAIL perf_mdstallcnt: got %0d expected %0d", mdstallcnt, exp_md); end
    endtask

    initial begin
        test_reset();
        test_forward_e();
        test_forward_d();
        test_stalls();
        test_md_timing();
        test_md_raw();
        test_back_to_back();
        test_reset_mid_busy();
        test_perf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
